dmem_bus_ctrl: RTL and testbench

- Multi-cycle data-memory controller between the single-cycle datapath's memory stage and the c_mem data memory.
- Converts the core's level-held load/store request into a one-cycle memory request.
- Waits for the memory's acknowledge, returns read data, and stalls the core until the access completes.
- A timeout counter prevents a lost acknowledge from hanging the core.

---
 rtl/dmem_bus_ctrl.sv | 147 ++++++++++++++
 tb/tb_dmem_bus_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_ctrl.sv
// Multi-cycle data-memory controller: turns the core's held load/store into a
// single memory request, waits for the acknowledge (or a timeout) and stalls the core.
module dmem_bus_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              store,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] w_data,
  input  logic [3:0]        masking,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] r_data,
  output logic              mem_request,
  output logic              mem_we_re,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_w_data,
  output logic [3:0]        mem_masking,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_r_data
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   r_data_q, r_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          mask_q, mask_d;

  // Byte-offset and upper address bits are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^{address[31:ADDR_W+2], address[1:0]};

  // Next-state, datapath capture and combinational stall
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_data_d = r_data_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    req_d    = 1'b0;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    stall    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (load || store) begin
          stall   = 1'b1;
          state_d = S_REQ;
          req_d   = 1'b1;
          addr_d  = address[ADDR_W+1:2];
          wdata_d = w_data;
          we_d    = store;
          mask_d  = store ? masking : 4'hF;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        cnt_d = '0;
        if (mem_valid) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (!we_q) r_data_d = mem_r_data;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        // An acknowledge in the final wait cycle still wins over the abort.
        if (mem_valid) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (!we_q) r_data_d = mem_r_data;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          if (!we_q) r_data_d = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      r_data_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_data_q <= r_data_d;
      done_q   <= done_d;
      err_q    <= err_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
    end
  end

  assign done        = done_q;
  assign err         = err_q;
  assign r_data      = r_data_q;
  assign mem_request = req_q;
  assign mem_we_re   = we_q;
  assign mem_address = addr_q;
  assign mem_w_data  = wdata_q;
  assign mem_masking = mask_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Bench for dmem_bus_ctrl: directed and random accesses checked against a
// transaction-level timing model (stall length, pulses, captured fields, load data).
module tb_dmem_bus_ctrl;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 15;

  logic              clk;
  logic              rst;
  logic              load, store;
  logic [31:0]       address;
  logic [DATA_W-1:0] w_data;
  logic [3:0]        masking;
  logic              stall, done, err;
  logic [DATA_W-1:0] r_data;
  logic              mem_request, mem_we_re;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_w_data;
  logic [3:0]        mem_masking;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_r_data;

  int n_vec = 0;
  int n_err = 0;

  // Model state: last completed load data and last captured request fields
  logic [31:0] exp_rdata;
  logic [7:0]  last_addr;
  logic [31:0] last_wdata;
  logic [3:0]  last_mask;
  logic        last_we;

  dmem_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .load(load), .store(store), .address(address),
    .w_data(w_data), .masking(masking), .stall(stall), .done(done), .err(err),
    .r_data(r_data), .mem_request(mem_request), .mem_we_re(mem_we_re),
    .mem_address(mem_address), .mem_w_data(mem_w_data), .mem_masking(mem_masking),
    .mem_valid(mem_valid), .mem_r_data(mem_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One cycle with no request; optional stray acknowledge must be ignored.
  task automatic idle_cycle(input logic stray);
    load       = 1'b0;
    store      = 1'b0;
    address    = $urandom;
    w_data     = $urandom;
    masking    = 4'($urandom);
    mem_valid  = stray;
    mem_r_data = $urandom;
    #3;
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_err", 32'(err), 32'd0);
    chk("idle_req", 32'(mem_request), 32'd0);
    chk("idle_rdata", r_data, exp_rdata);
    chk("idle_addr_hold", 32'(mem_address), 32'(last_addr));
    chk("idle_we_hold", 32'(mem_we_re), 32'(last_we));
    next_cycle();
  endtask

  // Full access: acknowledge arrives n cycles after the request cycle
  // (n > TIMEOUT means it never arrives in time).
  task automatic run_txn(input logic ld, input logic st, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [3:0] msk,
                         input int n, input logic [31:0] rd);
    bit ok;
    int len;
    ok  = (n <= int'(TIMEOUT));
    len = ok ? n + 2 : int'(TIMEOUT) + 2;
    last_addr  = adr[ADDR_W+1:2];
    last_wdata = wd;
    last_we    = st;
    last_mask  = st ? msk : 4'hF;
    for (int c = 0; c <= len; c++) begin
      load       = ld;
      store      = st;
      address    = adr;
      w_data     = wd;
      masking    = msk;
      mem_valid  = (c == n + 1);
      mem_r_data = (c == n + 1) ? rd : $urandom;
      #3;
      chk("stall", 32'(stall), 32'(c < len));
      chk("mem_request", 32'(mem_request), 32'(c == 1));
      chk("done", 32'(done), 32'(c == len));
      chk("err", 32'(err), 32'((c == len) && !ok));
      if (c >= 1) begin
        chk("mem_address", 32'(mem_address), 32'(last_addr));
        chk("mem_we_re", 32'(mem_we_re), 32'(last_we));
        chk("mem_masking", 32'(mem_masking), 32'(last_mask));
        chk("mem_w_data", mem_w_data, last_wdata);
      end
      if (c == len && !st) exp_rdata = ok ? rd : 32'd0;
      chk("r_data", r_data, exp_rdata);
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b0; load = 1'b1; store = 1'b0; address = 32'h10;
    w_data = '0; masking = '0; mem_valid = 1'b0; mem_r_data = '0;
    exp_rdata = '0; last_addr = '0; last_wdata = '0; last_mask = '0; last_we = 1'b0;

    // Reset held two cycles with a pending load
    next_cycle();
    next_cycle();
    #3;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_req", 32'(mem_request), 32'd0);
    chk("rst_rdata", r_data, 32'd0);
    chk("rst_we", 32'(mem_we_re), 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_wdata", mem_w_data, 32'd0);
    chk("rst_mask", 32'(mem_masking), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Load, zero wait
    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 32'hDEAD_BEEF);
    idle_cycle(1'b0);
    // Store, three-cycle wait
    run_txn(1'b0, 1'b1, 32'h0000_03FC, 32'h1234_5678, 4'b0011, 3, 32'hCAFE_0000);
    idle_cycle(1'b0);
    // Load timeout
    run_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 99, 32'h0);
    // Acknowledge in the last possible wait cycle
    run_txn(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h0, int'(TIMEOUT), 32'h5A5A_A5A5);
    // Stray acknowledge in IDLE
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    // Back-to-back load then store
    run_txn(1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'h0, 1, 32'h0BAD_F00D);
    run_txn(1'b0, 1'b1, 32'h0000_0084, 32'hFFFF_0000, 4'b1100, 0, 32'h1111_1111);
    // Load and store together act as a store
    run_txn(1'b1, 1'b1, 32'h0000_0088, 32'hA0A0_A0A0, 4'b0101, 2, 32'h2222_2222);
    // Store timeout leaves r_data alone
    run_txn(1'b0, 1'b1, 32'h0000_008C, 32'h1, 4'b1000, 99, 32'h0);

    // Reset in the middle of an access; a late acknowledge is ignored
    load = 1'b1; store = 1'b0; address = 32'h0000_00F0; mem_valid = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    rst = 1'b0; load = 1'b0;
    next_cycle();
    rst = 1'b1;
    exp_rdata = '0; last_addr = '0; last_wdata = '0; last_mask = '0; last_we = 1'b0;
    #3;
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_req", 32'(mem_request), 32'd0);
    chk("midrst_mask", 32'(mem_masking), 32'd0);
    chk("midrst_wdata", mem_w_data, 32'd0);
    next_cycle();
    idle_cycle(1'b1);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      int op;
      int n;
      op = int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) n = int'($urandom_range(0, TIMEOUT + 3));
      else n = int'($urandom_range(0, 4));
      run_txn(op != 1, op != 0, $urandom, $urandom, 4'($urandom), n, $urandom);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--)
        idle_cycle(1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
